// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with byte/half/word loads and stores, alignment checking and a small handshake FSM.
// Latency: a request sampled in IDLE gets its mem_ready (or misaligned) pulse in the next cycle; registered rdata is valid in that same cycle.
// Backpressure: requests are sampled only in IDLE; while busy is high they are ignored and must be held or reissued by the requester.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        misaligned,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RD_RESP, WR_ACK, FAULT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          unused_addr;

  logic          fault, ld_fire, st_fire;
  logic [3:0]    be;
  logic [31:0]   wlane, word, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Upper address bits are deliberately dropped so addresses alias.
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];
  assign word        = mem[idx];

  always_comb begin
    fault = 1'b0;
    if (Mem_Read && Mem_Write)                                  fault = 1'b1;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) fault = 1'b1;
    if (Mem_Write && funct3[2])                                 fault = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0])                        fault = 1'b1;
    if (funct3 == 3'b010 && addr[1:0] != 2'b00)                 fault = 1'b1;
  end

  assign ld_fire = (state == IDLE) && Mem_Read  && !fault;
  assign st_fire = (state == IDLE) && Mem_Write && !fault && !reset;

  always_comb begin
    ld_byte = word[7:0];
    case (addr[1:0])
      2'd1:    ld_byte = word[15:8];
      2'd2:    ld_byte = word[23:16];
      2'd3:    ld_byte = word[31:24];
      default: ld_byte = word[7:0];
    endcase
    ld_half = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick what lands.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      if (ld_fire) rdata <= ld_data;
    end
  end

  always_comb begin
    state_nxt  = IDLE;
    mem_ready  = 1'b0;
    misaligned = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (Mem_Read || Mem_Write) state_nxt = fault ? FAULT : (Mem_Read ? RD_RESP : WR_ACK);
      end
      RD_RESP, WR_ACK: mem_ready  = 1'b1;
      FAULT:           misaligned = 1'b1;
      default:         state_nxt  = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a table of single transactions plus hand-written reset and held-request sequences.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Read, Mem_Write;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        mem_ready, misaligned, busy;

  int errors = 0;
  int checks = 0;

  data_mem_ctrl #(.DEPTH_WORDS(256)) dut (
    .clk(clk), .reset(reset), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .addr(addr), .wdata(wdata), .funct3(funct3), .rdata(rdata),
    .mem_ready(mem_ready), .misaligned(misaligned), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f3;
    logic        fault;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic flt, input logic [31:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.f3 = f3; v.fault = flt; v.exp_rdata = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    Mem_Read = rd; Mem_Write = wr; addr = a; wdata = d; funct3 = f3;
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b010);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request for one cycle, then back to IDLE.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3);
    drive(rd, wr, a, d, f3);
    step();
    quiet();
    step();
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ready", {31'd0, mem_ready}, 32'd0);
    chk("reset_misaligned", {31'd0, misaligned}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    add(0, 1, 32'h10,  32'hDEADBEEF, 3'b010, 0, 32'h00000000);
    add(1, 0, 32'h10,  32'h0,        3'b010, 0, 32'hDEADBEEF);
    add(0, 1, 32'h11,  32'h80,       3'b000, 0, 32'hDEADBEEF);
    add(1, 0, 32'h11,  32'h0,        3'b000, 0, 32'hFFFFFF80);
    add(1, 0, 32'h11,  32'h0,        3'b100, 0, 32'h00000080);
    add(1, 0, 32'h12,  32'h0,        3'b001, 0, 32'hFFFFDEAD);
    add(1, 0, 32'h10,  32'h0,        3'b010, 0, 32'hDEAD80EF);
    add(0, 1, 32'h00,  32'h11223344, 3'b010, 0, 32'hDEAD80EF);
    add(1, 0, 32'h13,  32'h0,        3'b010, 1, 32'hDEAD80EF);
    add(0, 1, 32'h01,  32'h5555,     3'b001, 1, 32'hDEAD80EF);
    add(1, 0, 32'h10,  32'h0,        3'b110, 1, 32'hDEAD80EF);
    add(1, 0, 32'h00,  32'h0,        3'b010, 0, 32'h11223344);
    add(0, 1, 32'h20,  32'hCAFEF00D, 3'b010, 0, 32'h11223344);
    add(1, 1, 32'h20,  32'h0,        3'b010, 1, 32'h11223344);
    add(1, 0, 32'h20,  32'h0,        3'b010, 0, 32'hCAFEF00D);
    add(0, 1, 32'h410, 32'h0BADF00D, 3'b010, 0, 32'hCAFEF00D);
    add(1, 0, 32'h10,  32'h0,        3'b010, 0, 32'h0BADF00D);
    add(1, 0, 32'h12,  32'h0,        3'b101, 0, 32'h00000BAD);
    add(1, 0, 32'h10,  32'h0,        3'b001, 0, 32'hFFFFF00D);
    add(1, 0, 32'h13,  32'h0,        3'b000, 0, 32'h0000000B);
    add(0, 1, 32'h12,  32'hABCD1234, 3'b001, 0, 32'h0000000B);
    add(1, 0, 32'h10,  32'h0,        3'b010, 0, 32'h1234F00D);
    add(0, 1, 32'h10,  32'hFF,       3'b100, 1, 32'h1234F00D);
    add(1, 0, 32'h11,  32'h0,        3'b011, 1, 32'h1234F00D);
    add(1, 0, 32'h0F,  32'h0,        3'b111, 1, 32'h1234F00D);
    add(1, 0, 32'h11,  32'h0,        3'b001, 1, 32'h1234F00D);
    add(1, 0, 32'h10,  32'h0,        3'b010, 0, 32'h1234F00D);
    add(1, 0, 32'h812, 32'h0,        3'b101, 0, 32'h00001234);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].f3);
      chk($sformatf("vec%0d_pre_ready", i), {31'd0, mem_ready}, 32'd0);
      step();
      chk($sformatf("vec%0d_ready", i), {31'd0, mem_ready}, {31'd0, ~vecs[i].fault});
      chk($sformatf("vec%0d_misaligned", i), {31'd0, misaligned}, {31'd0, vecs[i].fault});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      quiet();
      step();
      chk($sformatf("vec%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("vec%0d_idle_ready", i), {31'd0, mem_ready}, 32'd0);
    end

    // Store held two cycles: second cycle lands in WR_ACK and is ignored.
    drive(0, 1, 32'h30, 32'd5, 3'b010);
    step();
    chk("hold2_ack", {31'd0, mem_ready}, 32'd1);
    wdata = 32'd6;
    step();
    chk("hold2_idle", {31'd0, busy}, 32'd0);
    quiet();
    xact(1, 0, 32'h30, 32'd0, 3'b010);
    chk("hold2_data", rdata, 32'd5);

    // Store held three cycles: writes at cycles 1 and 3.
    drive(0, 1, 32'h30, 32'd7, 3'b010);
    step();
    chk("hold3_ack1", {31'd0, mem_ready}, 32'd1);
    wdata = 32'd8;
    step();
    chk("hold3_gap", {31'd0, mem_ready}, 32'd0);
    wdata = 32'd9;
    step();
    chk("hold3_ack2", {31'd0, mem_ready}, 32'd1);
    quiet();
    step();
    xact(1, 0, 32'h30, 32'd0, 3'b010);
    chk("hold3_data", rdata, 32'd9);

    // Reset during RD_RESP.
    drive(1, 0, 32'h10, 32'd0, 3'b010);
    step();
    chk("rst_rd_ready_before", {31'd0, mem_ready}, 32'd1);
    quiet();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_rd_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rd_rdata", rdata, 32'd0);
    chk("rst_rd_busy", {31'd0, busy}, 32'd0);
    xact(1, 0, 32'h10, 32'd0, 3'b010);
    chk("rst_rd_array", rdata, 32'h1234F00D);

    // Store sampled with reset high must not commit.
    xact(0, 1, 32'h40, 32'h55, 3'b010);
    drive(0, 1, 32'h40, 32'h66, 3'b010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    quiet();
    chk("rst_st_busy", {31'd0, busy}, 32'd0);
    xact(1, 0, 32'h40, 32'd0, 3'b010);
    chk("rst_st_nocommit", rdata, 32'h55);

    // Reset during WR_ACK keeps the committed write.
    drive(0, 1, 32'h44, 32'h77, 3'b010);
    step();
    quiet();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_wr_ready", {31'd0, mem_ready}, 32'd0);
    xact(1, 0, 32'h44, 32'd0, 3'b010);
    chk("rst_wr_kept", rdata, 32'h77);

    // Reset during FAULT drops the pulse.
    drive(1, 0, 32'h13, 32'd0, 3'b010);
    step();
    chk("rst_flt_before", {31'd0, misaligned}, 32'd1);
    quiet();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_flt_mis", {31'd0, misaligned}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
